// File: rtl/reg_rd_fifo_pkg.sv
// Shared sizing and types for the reg_rd_fifo read-side drain buffer.
package reg_rd_fifo_pkg;
  localparam int RRF_WIDTH = 8;
  localparam int RRF_DEPTH = 4;
  localparam int PTR_W     = $clog2(RRF_DEPTH);
  localparam int LVL_W     = PTR_W + 1;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [LVL_W-1:0] lvl_t;
endpackage

// File: rtl/reg_rd_fifo_ptr.sv
// Wrapping circular-buffer pointer with increment enable and async active-low clear.
module reg_rd_fifo_ptr
  import reg_rd_fifo_pkg::*;
#(
  parameter int PW = PTR_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc_i,
  output logic [PW-1:0] cnt_o,
  output logic [PW-1:0] nxt_o
);
  logic [PW-1:0] cnt_q;
  logic [PW-1:0] cnt_d;

  // Depth is a power of two, so natural overflow gives the DEPTH-1 -> 0 wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i) begin
      cnt_d = cnt_q + PW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign nxt_o = cnt_d;
endmodule

// File: rtl/reg_rd_fifo.sv
// Show-ahead circular buffer between a register writer and a stalling consumer.
// Optional sticky drop flag port ovf is built when RRF_OVF_FLAG_EN is defined.
module reg_rd_fifo
  import reg_rd_fifo_pkg::*;
#(
  parameter int WIDTH = RRF_WIDTH,
  parameter int DEPTH = RRF_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  output logic                       wr_full,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH):0]     level
`ifdef RRF_OVF_FLAG_EN
  ,output logic                      ovf
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_s;
  logic [AW-1:0]    wr_ptr_nxt_s;
  logic [AW-1:0]    rd_ptr_s;
  logic [AW-1:0]    rd_ptr_nxt_s;
  logic             push_s;
  logic             pop_s;
  logic [LW-1:0]    level_q;
  logic [LW-1:0]    level_d;
  logic             wr_full_q;
  logic             rd_valid_q;
  logic [WIDTH-1:0] rd_data_q;
  logic [WIDTH-1:0] rd_data_d;

  assign push_s = wr_en & ~wr_full_q;
  assign pop_s  = rd_valid_q & rd_ready;

  reg_rd_fifo_ptr #(.PW(AW)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (push_s),
    .cnt_o (wr_ptr_s),
    .nxt_o (wr_ptr_nxt_s)
  );

  reg_rd_fifo_ptr #(.PW(AW)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (pop_s),
    .cnt_o (rd_ptr_s),
    .nxt_o (rd_ptr_nxt_s)
  );

  // Storage is deliberately not reset; status registers guard its contents.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_s] <= wr_data;
    end
  end

  always_comb begin
    level_d = level_q;
    case ({push_s, pop_s})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Next head word: the slot being written this cycle bypasses storage.
  always_comb begin
    rd_data_d = '0;
    if (level_d != '0) begin
      if (push_s && (rd_ptr_nxt_s == wr_ptr_s)) begin
        rd_data_d = wr_data;
      end else begin
        rd_data_d = mem_q[rd_ptr_nxt_s];
      end
    end else begin
      rd_data_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q    <= '0;
      wr_full_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      level_q    <= level_d;
      wr_full_q  <= (level_d == LVL_FULL);
      rd_valid_q <= (level_d != '0);
      rd_data_q  <= rd_data_d;
    end
  end

`ifdef RRF_OVF_FLAG_EN
  logic ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_q | (wr_en & wr_full_q);
    end
  end

  assign ovf = ovf_q;
`endif

  assign wr_full  = wr_full_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign level    = level_q;
endmodule
